// File: rtl/fetch_pkg.sv
// Shared types and widths for the fetch-stage PC controller.
package fetch_pkg;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
        logic              pred_taken;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched instructions; clear beats push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  fq_entry_t     din,
    output fq_entry_t     dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fq_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; no reset needed since empty entries are never presented.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC owner: one-outstanding I-cache requests, flush redirect, fetch queue.
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_stall,
    input  logic [31:0] btb_branchPC,
    input  logic        btb_flush,
    input  logic        btb_taken,
    output logic [31:0] pc_1,
    output logic        icache_req,
    output logic [31:0] icache_addr,
    input  logic        icache_ready,
    input  logic [31:0] icache_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_pred_taken,
    input  logic        id_ready
);

    localparam int CW = $clog2(FQ_DEPTH + 1);

    fetch_state_e  state;
    logic [31:0]   redirect_pc;
    logic          flush_take;
    logic          ack;
    logic          accept;
    logic          pop;
    logic          slot_free;
    logic          start;
    fq_entry_t     fq_din;
    fq_entry_t     fq_head;
    logic          fq_full;
    logic          fq_empty;
    logic [CW-1:0] fq_count;

    // Handshake decode; a new request may only start if the queue will still
    // have room after this cycle's enqueue/dequeue (slot reserved at start).
    always_comb begin
        flush_take = btb_flush && !memory_stall;
        ack        = icache_req && icache_ready;
        accept     = (state == RUN) && ack && !flush_take;
        pop        = if_valid && id_ready;
        if (accept) begin
            slot_free = (fq_count < CW'(FQ_DEPTH - 1)) || pop;
        end else begin
            slot_free = !fq_full || pop;
        end
        start = (state == RUN) && (!icache_req || ack) && !memory_stall
                && !flush_take && slot_free;
        fq_din = '{pc: pc_1, inst: icache_rdata, pred_taken: btb_taken};
    end

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .clear (flush_take),
        .din   (fq_din),
        .dout  (fq_head),
        .full  (fq_full),
        .empty (fq_empty),
        .count (fq_count)
    );

    assign if_valid      = !fq_empty;
    assign if_inst       = if_valid ? fq_head.inst : '0;
    assign if_pc         = if_valid ? fq_head.pc : '0;
    assign if_pred_taken = if_valid && fq_head.pred_taken;

    // PC / request / redirect state machine; an in-flight request is never dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc_1        <= RESET_PC;
            icache_addr <= RESET_PC;
            icache_req  <= 1'b0;
            redirect_pc <= '0;
        end else begin
            if (icache_req && !icache_ready) begin
                icache_req <= 1'b1;
            end else begin
                icache_req <= start;
            end

            case (state)
                RUN: begin
                    if (flush_take) begin
                        if (icache_req && !icache_ready) begin
                            redirect_pc <= btb_branchPC;
                            state       <= DRAIN;
                        end else begin
                            pc_1        <= btb_branchPC;
                            icache_addr <= btb_branchPC;
                        end
                    end else if (accept) begin
                        pc_1        <= btb_branchPC;
                        icache_addr <= btb_branchPC;
                    end
                end
                DRAIN: begin
                    if (flush_take) begin
                        redirect_pc <= btb_branchPC;
                    end
                    if (icache_ready) begin
                        // A flush landing on the same cycle as the drain ack wins.
                        pc_1        <= flush_take ? btb_branchPC : redirect_pc;
                        icache_addr <= flush_take ? btb_branchPC : redirect_pc;
                        state       <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with hand-computed expectations.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        memory_stall;
    logic [31:0] btb_branchPC;
    logic        btb_flush;
    logic        btb_taken;
    logic [31:0] pc_1;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_ready;
    logic [31:0] icache_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        id_ready;

    logic        ovr_en;
    logic [31:0] ovr_pc;
    int          n_checks = 0;
    int          n_errors = 0;
    int          acks;

    always #5 clk = ~clk;

    // BTB model: sequential next-PC unless a directed target is forced.
    assign btb_branchPC = ovr_en ? ovr_pc : pc_1 + 32'd4;
    assign icache_rdata = icache_addr ^ KEY;

    fetch_pc_ctrl #(.RESET_PC(32'h0000_0100), .FQ_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .memory_stall  (memory_stall),
        .btb_branchPC  (btb_branchPC),
        .btb_flush     (btb_flush),
        .btb_taken     (btb_taken),
        .pc_1          (pc_1),
        .icache_req    (icache_req),
        .icache_addr   (icache_addr),
        .icache_ready  (icache_ready),
        .icache_rdata  (icache_rdata),
        .if_valid      (if_valid),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .id_ready      (id_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        memory_stall = 1'b0;
        btb_flush    = 1'b0;
        btb_taken    = 1'b0;
        ovr_en       = 1'b0;
        ovr_pc       = '0;
        icache_ready = 1'b1;
        id_ready     = 1'b1;

        // Reset values and sequential fetch.
        rst = 1'b1;
        tick();
        tick();
        check("rst_pc", pc_1, 32'h100);
        check("rst_req", 32'(icache_req), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_addr", icache_addr, 32'h100);
        check("rst_inst", if_inst, 32'h0);
        check("rst_ifpc", if_pc, 32'h0);
        check("rst_pred", 32'(if_pred_taken), 32'd0);
        rst = 1'b0;
        tick();
        check("p1_req", 32'(icache_req), 32'd1);
        check("p1_addr", icache_addr, 32'h100);
        tick();
        check("seq0_pc", if_pc, 32'h100);
        check("seq0_inst", if_inst, 32'hDEAD_0100);
        check("seq0_pred", 32'(if_pred_taken), 32'd0);
        tick();
        check("seq1_pc", if_pc, 32'h104);
        check("seq1_pc1", pc_1, 32'h108);
        btb_taken = 1'b1;
        ovr_en    = 1'b1;
        ovr_pc    = 32'h200;
        tick();
        check("tkn_ifpc", if_pc, 32'h108);
        check("tkn_pred", 32'(if_pred_taken), 32'd1);
        check("tkn_addr", icache_addr, 32'h200);
        btb_taken = 1'b0;
        ovr_en    = 1'b0;
        tick();
        check("tkn_next", if_pc, 32'h200);
        check("tkn_next_pred", 32'(if_pred_taken), 32'd0);

        // Back-pressure: queue fills to exactly 4 and requests stop.
        id_ready = 1'b0;
        do_reset();
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (icache_req) acks++;
        end
        check("full_acks", 32'(acks), 32'd4);
        check("full_req", 32'(icache_req), 32'd0);
        check("full_head", if_pc, 32'h100);
        check("full_pc1", pc_1, 32'h110);
        id_ready = 1'b1;
        tick();
        check("one_req", 32'(icache_req), 32'd1);
        check("one_head", if_pc, 32'h104);
        id_ready = 1'b0;
        tick();
        check("one_drop", 32'(icache_req), 32'd0);
        check("one_pc1", pc_1, 32'h114);
        check("one_head2", if_pc, 32'h104);
        // Steady stream at 3 entries: simultaneous enq/deq across pointer wrap.
        id_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("wrap_valid", 32'(if_valid), 32'd1);
            check("wrap_pc", if_pc, 32'h108 + 32'(4 * i));
        end
        check("wrap_inst", if_inst, 32'hDEAD_011C);

        // Flush while a slow request is in flight.
        icache_ready = 1'b0;
        id_ready     = 1'b1;
        do_reset();
        tick();
        check("dr_req0", 32'(icache_req), 32'd1);
        btb_flush = 1'b1;
        ovr_en    = 1'b1;
        ovr_pc    = 32'h400;
        tick();
        check("dr_hold_req", 32'(icache_req), 32'd1);
        check("dr_hold_addr", icache_addr, 32'h100);
        check("dr_hold_pc", pc_1, 32'h100);
        check("dr_valid", 32'(if_valid), 32'd0);
        btb_flush = 1'b0;
        ovr_en    = 1'b0;
        tick();
        check("dr_hold_addr2", icache_addr, 32'h100);
        icache_ready = 1'b1;
        tick();
        check("dr_done_req", 32'(icache_req), 32'd0);
        check("dr_done_pc", pc_1, 32'h400);
        check("dr_discard", 32'(if_valid), 32'd0);
        tick();
        check("dr_new_req", 32'(icache_req), 32'd1);
        check("dr_new_addr", icache_addr, 32'h400);
        check("dr_still_empty", 32'(if_valid), 32'd0);
        tick();
        check("dr_first_pc", if_pc, 32'h400);
        check("dr_first_inst", if_inst, 32'hDEAD_0400);

        // Flush blocked by memory_stall, taken once the stall releases.
        icache_ready = 1'b1;
        id_ready     = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) tick();
        memory_stall = 1'b1;
        btb_flush    = 1'b1;
        ovr_en       = 1'b1;
        ovr_pc       = 32'h500;
        tick();
        check("st_pc", pc_1, 32'h110);
        check("st_valid", 32'(if_valid), 32'd1);
        check("st_head", if_pc, 32'h100);
        memory_stall = 1'b0;
        id_ready     = 1'b1;
        tick();
        check("st_fl_pc", pc_1, 32'h500);
        check("st_fl_addr", icache_addr, 32'h500);
        check("st_fl_valid", 32'(if_valid), 32'd0);
        btb_flush = 1'b0;
        ovr_en    = 1'b0;
        tick();
        check("st_req", 32'(icache_req), 32'd1);
        check("st_req_addr", icache_addr, 32'h500);

        // Reset during an outstanding request abandons it.
        icache_ready = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_abandon", 32'(icache_req), 32'd0);
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage controller that owns the program counter and sits directly downstream of the branch target buffer. It drives the current PC into the BTB, consumes the BTB's next-PC, flush and taken outputs, and issues one-outstanding instruction-cache requests. Fetched instructions are buffered, tagged with their PC and predicted-taken bit, in a small FIFO. Decode drains the FIFO over a valid/ready handshake; the predicted-taken bit travels down the pipe and returns to the BTB as the stage-3 previous-taken flag.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded at reset.
- FQ_DEPTH, 4: fetch-queue entries; power of two, at least 2.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- memory_stall  in  1  global stall; blocks starting a new request and blocks acting on a flush.
- btb_branchPC  in  32  next PC from the BTB: prediction, or the corrected target when btb_flush=1.
- btb_flush  in  1  stage-3 mispredict redirect.
- btb_taken  in  1  prediction for pc_1.
- pc_1  out  32  current fetch PC; drives the BTB's stage-1 PC input.
- icache_req  out  1  request valid.
- icache_addr  out  32  request address.
- icache_ready  in  1  single-cycle acknowledge; icache_rdata is valid in the same cycle.
- icache_rdata  in  32  instruction word.
- if_valid  out  1  queue head valid.
- if_inst  out  32  head instruction.
- if_pc  out  32  head PC.
- if_pred_taken  out  1  head predicted-taken bit.
- id_ready  in  1  decode accepts the head.

## Operation
- States:
  - RUN: normal fetch.
  - DRAIN: a flush arrived while a request was still in flight; wait for it to finish and discard the response.
- Request rule:
  - In RUN, a request starts when the queue has a free slot, memory_stall=0 and no flush is being taken.
  - Once icache_req is high, it stays high and icache_addr stays unchanged until icache_ready. This holds regardless of memory_stall, flush or queue state.
  - Only one request is outstanding at a time. icache_addr equals pc_1 in RUN.
- Acceptance in RUN: icache_ready=1 with no flush taken causes all of the following:
  - Enqueue {pc_1, icache_rdata, btb_taken}.
  - pc_1 <= btb_branchPC.
- A flush is taken only when btb_flush=1 and memory_stall=0.
  - The queue is cleared. Any same-cycle dequeue is void.
  - If no request is in flight, or the flush coincides with icache_ready: the response is discarded, pc_1 <= btb_branchPC, and the state stays RUN.
  - If a request is in flight and icache_ready=0: redirect_pc <= btb_branchPC and the state goes to DRAIN.
- DRAIN:
  - icache_req stays high with the old address.
  - A further taken flush overwrites redirect_pc.
  - On icache_ready the response is dropped, pc_1 <= redirect_pc, and the state returns to RUN.
- Queue:
  - Circular buffer with read and write pointers that wrap modulo FQ_DEPTH.
  - Count width is clog2(FQ_DEPTH+1).
  - Dequeue happens when if_valid && id_ready.
  - Enqueue and dequeue may occur in the same cycle; the count is unchanged.
  - Full means count==FQ_DEPTH. A slot is reserved at request start, so an acknowledged response always finds room.
- PC arithmetic is 32-bit and wraps modulo 2^32. The block does not compute PC+4 itself; that comes from btb_branchPC.

## Timing
- Reset values:
  - pc_1=RESET_PC, icache_req=0, if_valid=0, state RUN, queue empty, redirect_pc=0.
  - icache_addr=RESET_PC. if_inst, if_pc and if_pred_taken are all 0.
- The first request is raised in the cycle after rst deasserts.
- icache_req is registered.
  - A new request rises one cycle after its start condition holds.
  - Back-to-back fetch is allowed: the request drops only if the start condition fails after an acknowledge.
- Enqueue-to-if_valid latency is 1 cycle. There is no bypass from icache_rdata.
- A taken flush causes all of the following in the next cycle:
  - if_valid=0.
  - If the state is RUN, the new PC is on pc_1 and icache_addr.
- rst asserted mid-request abandons the request: icache_req=0 in the next cycle. The cache must tolerate this.
- memory_stall never suppresses an in-flight acknowledge, and never suppresses a dequeue.

## Structure
- Package fetch_pkg holds:
  - fetch_state_e with values RUN and DRAIN.
  - fq_entry_t = {pc[31:0], inst[31:0], pred_taken}.
  - Width constants for the PC and instruction fields.
- Sub-module fetch_queue: a parameterized synchronous FIFO of fq_entry_t with push, pop, clear, full, empty and count. Clear takes priority over push and pop.

## Test plan
- Reset with RESET_PC=0x100, cache always ready, btb_branchPC=pc+4, btb_taken=0, id_ready=1 → if_pc sequence 0x100, 0x104, 0x108, one per cycle; if_pred_taken=0.
- btb_taken=1 with btb_branchPC=0x200 while pc_1=0x108 → entry {0x108, pred_taken=1} is enqueued; the next icache_addr is 0x200.
- id_ready=0 with FQ_DEPTH=4 → exactly 4 entries are enqueued and icache_req drops. Raising id_ready for one cycle → a single new request issues and the head PC advances.
- Cache acknowledges 3 cycles after the request; a flush to 0x400 arrives in the cycle after the request rises → icache_addr holds the old PC until the acknowledge, the response is discarded, the next request goes to 0x400, and the queue stays empty.
- btb_flush=1 while memory_stall=1 → no change to the PC or queue. Releasing memory_stall the next cycle → the flush is taken then.
- Simultaneous enqueue and dequeue while the queue holds 3 entries → count stays 3 and the write pointer wraps correctly across index 3→0.
